// File: rtl/packet_injector.sv
// Purpose    : local-port injector for a mesh node; filters, queues, stamps and sends packets.
// Latency    : a packet accepted into an empty queue is presented two edges later; then 1 flit/cycle.
// Backpressure: o_tx_ready drops when the queue is full; a blocked flit holds until i_flit_ready.
//
// Ports:
//   i_clk, i_rst_n              clock (rising edge), asynchronous active-low reset
//   i_id                        this node's address, static after reset
//   i_tx_valid/o_tx_ready       core request handshake; o_tx_ready = queue not full
//   i_tx_dest, i_tx_data        requested destination and payload
//   o_flit_valid/i_flit_ready   router local-port handshake (o_flit_valid registered)
//   o_flit_out                  {dest, src, seq, data}
//   o_lb_valid, o_lb_data       one-cycle loopback of a self-addressed packet
//   o_drop_cnt                  saturating count of illegal-destination packets
//   o_stall_err                 sticky flag: output blocked STALL_MAX consecutive cycles
module packet_injector #(
    parameter int ADDR_SZ   = 4,
    parameter int NODES     = 9,
    parameter int DATA_SZ   = 8,
    parameter int SEQ_SZ    = 4,
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 15
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [ADDR_SZ-1:0]                i_id,
    input  logic                              i_tx_valid,
    output logic                              o_tx_ready,
    input  logic [ADDR_SZ-1:0]                i_tx_dest,
    input  logic [DATA_SZ-1:0]                i_tx_data,
    output logic                              o_flit_valid,
    input  logic                              i_flit_ready,
    output logic [2*ADDR_SZ+SEQ_SZ+DATA_SZ-1:0] o_flit_out,
    output logic                              o_lb_valid,
    output logic [DATA_SZ-1:0]                o_lb_data,
    output logic [7:0]                        o_drop_cnt,
    output logic                              o_stall_err
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    typedef struct packed {
        logic [ADDR_SZ-1:0] dest;
        logic [DATA_SZ-1:0] data;
    } ent_t;

    typedef struct packed {
        logic [ADDR_SZ-1:0] dest;
        logic [ADDR_SZ-1:0] src;
        logic [SEQ_SZ-1:0]  seq;
        logic [DATA_SZ-1:0] data;
    } flit_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    ent_t               r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_avail;
    state_t             r_state;
    state_t             w_state_next;
    flit_t              r_flit;
    logic [SEQ_SZ-1:0]  r_seq;
    logic               r_lb_valid;
    logic [DATA_SZ-1:0] r_lb_data;
    logic [7:0]         r_drop_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [STALL_W-1:0] w_stall_next;
    logic               r_stall_err;

    logic               w_tx_ready;
    logic               w_hs;
    logic               w_illegal;
    logic               w_self;
    logic               w_push;
    logic               w_load;
    logic               w_blocked;
    ent_t               w_head;

    // ------------------------------------------------------------------
    // Request side: handshake and filtering
    // ------------------------------------------------------------------
    // Ready reflects the registered count only, so a pop in the same cycle
    // never opens a slot early.
    assign w_tx_ready = (r_count < CNT_W'(DEPTH));
    assign w_hs       = i_tx_valid & w_tx_ready;
    assign w_illegal  = (32'(i_tx_dest) >= NODES);
    assign w_self     = !w_illegal && (i_tx_dest == i_id);
    assign w_push     = w_hs & !w_illegal & !w_self;
    assign w_head     = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Queue storage (no reset needed: validity is tracked by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{dest: i_tx_dest, data: i_tx_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_avail  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Occupancy delayed by one cycle: an idle sender only starts on
            // entries that have sat in the queue for a full cycle, giving
            // the two-edge accept-to-present latency.
            r_avail <= (r_count != '0);
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (r_avail) w_state_next = S_SEND;
            S_SEND: if (i_flit_ready && (r_count == '0)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output FSM: outputs (load strobe doubles as the queue pop)
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            S_IDLE:  w_load = r_avail;
            S_SEND:  w_load = i_flit_ready && (r_count != '0);
            default: w_load = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Flit register and sequence number
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flit <= '0;
            r_seq  <= '0;
        end else if (w_load) begin
            r_flit <= '{dest: w_head.dest, src: i_id, seq: r_seq, data: w_head.data};
            r_seq  <= r_seq + SEQ_SZ'(1);
        end
    end

    // ------------------------------------------------------------------
    // Loopback and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lb_valid <= 1'b0;
            r_lb_data  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_lb_valid <= w_hs & w_self;
            if (w_hs && w_self) r_lb_data <= i_tx_data;
            if (w_hs && w_illegal && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall watchdog: consecutive cycles with a flit presented but refused
    // ------------------------------------------------------------------
    assign w_blocked = (r_state == S_SEND) && !i_flit_ready;

    always_comb begin
        w_stall_next = '0;
        if (w_blocked) begin
            if (r_stall_cnt == STALL_W'(STALL_MAX)) w_stall_next = r_stall_cnt;
            else                                    w_stall_next = r_stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_next;
            if (w_stall_next == STALL_W'(STALL_MAX)) r_stall_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tx_ready   = w_tx_ready;
    assign o_flit_valid = (r_state == S_SEND);
    assign o_flit_out   = r_flit;
    assign o_lb_valid   = r_lb_valid;
    assign o_lb_data    = r_lb_data;
    assign o_drop_cnt   = r_drop_cnt;
    assign o_stall_err  = r_stall_err;

endmodule

// File: tb/tb_packet_injector.sv
// Purpose    : randomized bench for packet_injector against a queue-based reference model.
// Latency    : model advances once per clock edge; outputs sampled on the falling edge.
// Backpressure: i_flit_ready driven from directed and random patterns.
module tb_packet_injector;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dest;
    logic [7:0]  tx_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [19:0] flit_out;
    logic        lb_valid;
    logic [7:0]  lb_data;
    logic [7:0]  drop_cnt;
    logic        stall_err;

    packet_injector dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_id         (id),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .i_tx_dest    (tx_dest),
        .i_tx_data    (tx_data),
        .o_flit_valid (flit_valid),
        .i_flit_ready (flit_ready),
        .o_flit_out   (flit_out),
        .o_lb_valid   (lb_valid),
        .o_lb_data    (lb_data),
        .o_drop_cnt   (drop_cnt),
        .o_stall_err  (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of accepted packets, each tagged with the
    // edge it arrived on, plus the presented flit and side counters.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] dest;
        logic [7:0] data;
        int         stamp;
    } pkt_t;

    pkt_t       m_q[$];
    bit         m_fv;
    logic [19:0] m_fo;
    logic [3:0] m_seq;
    bit         m_lbv;
    logic [7:0] m_lbd;
    int         m_drop;
    int         m_blk;
    bit         m_err;
    int         cyc;

    task automatic model_reset();
        m_q.delete();
        m_fv = 0; m_fo = '0; m_seq = '0; m_lbv = 0; m_lbd = '0;
        m_drop = 0; m_blk = 0; m_err = 0;
    endtask

    task automatic model_present();
        pkt_t p;
        p = m_q.pop_front();
        m_fo = {p.dest, id, m_seq, p.data};
        m_seq = m_seq + 4'd1;
        m_fv = 1;
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic tick(input bit v, input logic [3:0] d, input logic [7:0] dat, input bit fr);
        bit rdy;
        bit hs;
        pkt_t p;
        tx_valid = v; tx_dest = d; tx_data = dat; flit_ready = fr;
        #1;
        rdy = (m_q.size() < 4);
        check("tx_ready", 32'(tx_ready), 32'(rdy));
        hs = v && rdy;

        // refused presentation streak
        if (m_fv && !fr) begin
            m_blk = m_blk + 1;
            if (m_blk >= 15) m_err = 1;
        end else begin
            m_blk = 0;
        end

        // sender: idle starts only on a packet at least two edges old
        if (!m_fv) begin
            if (m_q.size() > 0 && m_q[0].stamp <= cyc - 2) model_present();
        end else if (fr) begin
            if (m_q.size() > 0) model_present();
            else m_fv = 0;
        end

        // request side
        m_lbv = 0;
        if (hs) begin
            if (d >= 4'd9) begin
                if (m_drop < 255) m_drop = m_drop + 1;
            end else if (d == id) begin
                m_lbv = 1;
                m_lbd = dat;
            end else begin
                p.dest = d; p.data = dat; p.stamp = cyc;
                m_q.push_back(p);
            end
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("flit_valid", 32'(flit_valid), 32'(m_fv));
        check("flit_out",   32'(flit_out),   32'(m_fo));
        check("lb_valid",   32'(lb_valid),   32'(m_lbv));
        if (m_lbv) check("lb_data", 32'(lb_data), 32'(m_lbd));
        check("drop_cnt",   32'(drop_cnt),   32'(m_drop));
        check("stall_err",  32'(stall_err),  32'(m_err));
    endtask

    task automatic idle(input int n, input bit fr);
        for (int i = 0; i < n; i++) tick(0, 4'd0, 8'd0, fr);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset(input logic [3:0] new_id);
        tx_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check("rst_flit_valid", 32'(flit_valid), 32'd0);
        check("rst_flit_out",   32'(flit_out),   32'd0);
        check("rst_lb_valid",   32'(lb_valid),   32'd0);
        check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
        check("rst_stall_err",  32'(stall_err),  32'd0);
        id = new_id;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [3:0] rand_dest();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      return 4'($urandom_range(9, 15));
        else if (r == 1) return id;
        else             return 4'($urandom_range(0, 8));
    endfunction

    initial begin
        rst_n = 0; id = 4'd4; tx_valid = 0; tx_dest = '0; tx_data = '0; flit_ready = 0;
        cyc = 0;
        model_reset();
        @(negedge clk);
        check("init_flit_valid", 32'(flit_valid), 32'd0);
        check("init_tx_ready",   32'(tx_ready),   32'd1);
        check("init_stall_err",  32'(stall_err),  32'd0);
        @(negedge clk);
        rst_n = 1;
        idle(2, 1);

        // T1: single packet, two-edge latency, present for exactly one cycle
        tick(1, 4'd8, 8'hA5, 1);
        tick(0, 4'd0, 8'd0, 1);
        check("t1_not_yet", 32'(flit_valid), 32'd0);
        tick(0, 4'd0, 8'd0, 1);
        check("t1_valid", 32'(flit_valid), 32'd1);
        check("t1_flit",  32'(flit_out),   32'h840A5);
        tick(0, 4'd0, 8'd0, 1);
        check("t1_one_cycle", 32'(flit_valid), 32'd0);

        // T3: self-addressed packet loops back, nothing injected
        tick(1, 4'd4, 8'h3C, 1);
        check("t3_lb_valid", 32'(lb_valid), 32'd1);
        check("t3_lb_data",  32'(lb_data),  32'h3C);
        tick(0, 4'd0, 8'd0, 1);
        check("t3_lb_pulse", 32'(lb_valid), 32'd0);
        idle(2, 1);
        check("t3_no_flit", 32'(flit_valid), 32'd0);

        // T4: illegal destinations are dropped and counted, saturating
        tick(1, 4'd9, 8'h01, 1);
        tick(1, 4'd15, 8'h02, 1);
        check("t4_drop2", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 300; i++) tick(1, 4'($urandom_range(9, 15)), 8'($urandom), 1);
        check("t4_drop_sat", 32'(drop_cnt), 32'd255);
        check("t4_no_flit",  32'(flit_valid), 32'd0);

        // T2: fill with router blocked, then drain back-to-back
        do_reset(4'd4);
        for (int i = 0; i < 6; i++) tick(1, 4'(i % 4), 8'(8'h10 + i), 0);
        check("t2_full", 32'(tx_ready), 32'd0);
        idle(8, 1);

        // T5: sequence wrap over 17 packets, then a long stall
        for (int i = 0; i < 17; i++) tick(1, 4'd1, 8'(i), 1);
        idle(4, 1);
        tick(1, 4'd2, 8'h77, 1);
        idle(2, 1);
        idle(16, 0);
        check("t5_stall_err", 32'(stall_err), 32'd1);
        idle(4, 1);
        check("t5_sticky", 32'(stall_err), 32'd1);

        // T6: reset while sending with packets queued
        for (int i = 0; i < 5; i++) tick(1, 4'd6, 8'(8'h40 + i), 0);
        do_reset(4'd4);
        check("t6_tx_ready", 32'(tx_ready), 32'd1);
        tick(1, 4'd7, 8'h99, 1);
        idle(2, 1);
        check("t6_valid", 32'(flit_valid), 32'd1);
        check("t6_seq0",  32'(flit_out[11:8]), 32'd0);
        idle(2, 1);

        // Random traffic under varying backpressure and node ids
        for (int ph = 0; ph < 8; ph++) begin
            int rp;
            rp = (ph % 4 == 0) ? 100 : (ph % 4 == 1) ? 70 : (ph % 4 == 2) ? 30 : 5;
            if (ph == 4) do_reset(4'd0);
            for (int i = 0; i < 300; i++) begin
                tick(($urandom_range(0, 99) < 70), rand_dest(), 8'($urandom),
                     ($urandom_range(0, 99) < rp));
            end
            idle(10, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
